// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and data-memory
// wait handling with a bounded timeout, plus stall and flush statistics.
module hazard_controller #(
  parameter int unsigned Index_size  = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Index_size-1:0] idRa,
  input  logic [Index_size-1:0] idRb,
  input  logic [Index_size-1:0] idRc,
  input  logic                  idUsesRb,
  input  logic                  idIsStore,
  input  logic [Index_size-1:0] exRd,
  input  logic                  exMemToReg,
  input  logic                  exRegWrite,
  input  logic                  exBranchTaken,
  input  logic                  memReq,
  input  logic                  memReady,
  output logic                  pcEn,
  output logic                  ifIdEn,
  output logic                  idExEn,
  output logic                  exMemEn,
  output logic                  ifIdFlush,
  output logic                  idExFlush,
  output logic [1:0]            state,
  output logic                  memTimeout,
  output logic [CNT_W-1:0]      stallCycles,
  output logic [7:0]            flushCount
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StBubble  = 2'b01,
    StMemWait = 2'b10,
    StFlush   = 2'b11
  } state_e;

  state_e           r_state, w_state_d;
  logic             r_ret_flush, w_ret_flush_d;
  logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_d;
  logic             w_load_use, w_mem_stall, w_timeout_hit, w_branch_evt;

  assign w_load_use = exMemToReg & exRegWrite &
                      ((exRd == idRa) | (idUsesRb & (exRd == idRb)) |
                       (idIsStore & (exRd == idRc)));
  assign w_mem_stall   = memReq & ~memReady;
  assign w_timeout_hit = (r_state == StMemWait) && (r_wait_cnt == WaitW'(MEM_TIMEOUT - 1));
  assign state         = r_state;

  always_comb begin
    w_state_d     = r_state;
    w_ret_flush_d = r_ret_flush;
    w_wait_cnt_d  = r_wait_cnt;
    w_branch_evt  = 1'b0;
    pcEn          = 1'b1;
    ifIdEn        = 1'b1;
    idExEn        = 1'b1;
    exMemEn       = 1'b1;
    ifIdFlush     = 1'b0;
    idExFlush     = 1'b0;
    case (r_state)
      StMemWait: begin
        if (memReady || w_timeout_hit) begin
          w_wait_cnt_d  = '0;
          w_ret_flush_d = 1'b0;
          w_state_d     = r_ret_flush ? StFlush : StRun;
        end else begin
          {pcEn, ifIdEn, idExEn, exMemEn} = 4'b0000;
          w_wait_cnt_d = r_wait_cnt + WaitW'(1);
        end
      end
      default: begin
        if (w_mem_stall) begin
          {pcEn, ifIdEn, idExEn, exMemEn} = 4'b0000;
          w_ret_flush_d = (r_state == StFlush);
          w_wait_cnt_d  = '0;
          w_state_d     = StMemWait;
        end else if (exBranchTaken) begin
          ifIdFlush    = 1'b1;
          idExFlush    = 1'b1;
          w_branch_evt = 1'b1;
          w_state_d    = StFlush;
        end else if (w_load_use && (r_state == StRun)) begin
          pcEn      = 1'b0;
          ifIdEn    = 1'b0;
          idExFlush = 1'b1;
          w_state_d = StBubble;
        end else begin
          // FLUSH keeps squashing IF/ID for its second cycle
          ifIdFlush = (r_state == StFlush);
          w_state_d = StRun;
        end
      end
    endcase
    // Reset masks any live hazard inputs so the pipeline sees plain RUN behaviour
    if (!rst) begin
      {pcEn, ifIdEn, idExEn, exMemEn} = 4'b1111;
      ifIdFlush = 1'b0;
      idExFlush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StRun;
      r_ret_flush <= 1'b0;
      r_wait_cnt  <= '0;
      memTimeout  <= 1'b0;
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_ret_flush <= w_ret_flush_d;
      r_wait_cnt  <= w_wait_cnt_d;
      if (w_timeout_hit) memTimeout <= 1'b1;
      if (!pcEn && (stallCycles != '1)) stallCycles <= stallCycles + CNT_W'(1);
      if (w_branch_evt && (flushCount != 8'hFF)) flushCount <= flushCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus a randomized run
// against a behavioural model of the hazard rules.
module tb_hazard_controller;

  localparam int MemTimeout = 15;
  localparam logic [1:0] S_RUN = 2'b00, S_BUB = 2'b01, S_MW = 2'b10, S_FL = 2'b11;

  logic        clk, rst;
  logic [3:0]  idRa, idRb, idRc, exRd;
  logic        idUsesRb, idIsStore, exMemToReg, exRegWrite, exBranchTaken, memReq, memReady;
  logic        pcEn, ifIdEn, idExEn, exMemEn, ifIdFlush, idExFlush, memTimeout;
  logic [1:0]  state;
  logic [15:0] stallCycles;
  logic [7:0]  flushCount;
  logic [5:0]  ctl;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [1:0]  m_state;
  logic        m_ret, m_timeout;
  int          m_wait;
  logic [15:0] m_stall;
  logic [7:0]  m_flush;
  // Model predictions for the current cycle
  logic [3:0]  e_en;
  logic        e_iff, e_ief, e_nret, e_tohit, e_brevt;
  logic [1:0]  e_nstate;
  int          e_nwait;

  hazard_controller dut (
    .clk(clk), .rst(rst), .idRa(idRa), .idRb(idRb), .idRc(idRc), .idUsesRb(idUsesRb),
    .idIsStore(idIsStore), .exRd(exRd), .exMemToReg(exMemToReg), .exRegWrite(exRegWrite),
    .exBranchTaken(exBranchTaken), .memReq(memReq), .memReady(memReady), .pcEn(pcEn),
    .ifIdEn(ifIdEn), .idExEn(idExEn), .exMemEn(exMemEn), .ifIdFlush(ifIdFlush),
    .idExFlush(idExFlush), .state(state), .memTimeout(memTimeout),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  assign ctl = {pcEn, ifIdEn, idExEn, exMemEn, ifIdFlush, idExFlush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    idRa = 0; idRb = 0; idRc = 0; exRd = 0;
    idUsesRb = 0; idIsStore = 0; exMemToReg = 0; exRegWrite = 0;
    exBranchTaken = 0; memReq = 0; memReady = 0;
  endtask

  task automatic model_reset();
    m_state = S_RUN; m_ret = 0; m_timeout = 0; m_wait = 0; m_stall = 0; m_flush = 0;
  endtask

  // Classify the cycle's event by priority, then derive outputs and next mode
  task automatic model_eval();
    bit lu, ms, release_now;
    lu = exMemToReg && exRegWrite && ((exRd == idRa) || (idUsesRb && exRd == idRb) ||
                                      (idIsStore && exRd == idRc));
    ms = memReq && !memReady;
    e_en = 4'hF; e_iff = 0; e_ief = 0; e_tohit = 0; e_brevt = 0;
    e_nstate = m_state; e_nret = m_ret; e_nwait = m_wait;
    if (m_state == S_MW) begin
      e_tohit = (m_wait == MemTimeout - 1);
      release_now = memReady || e_tohit;
      if (release_now) begin
        e_nstate = m_ret ? S_FL : S_RUN; e_nwait = 0; e_nret = 0;
      end else begin
        e_en = 4'h0; e_nwait = m_wait + 1;
      end
    end else if (ms) begin
      e_en = 4'h0; e_nstate = S_MW; e_nret = (m_state == S_FL); e_nwait = 0;
    end else if (exBranchTaken) begin
      e_iff = 1; e_ief = 1; e_nstate = S_FL; e_brevt = 1;
    end else if (lu && m_state == S_RUN) begin
      e_en = 4'b0011; e_ief = 1; e_nstate = S_BUB;
    end else begin
      e_iff = (m_state == S_FL); e_nstate = S_RUN;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
    if (e_tohit) m_timeout = 1;
    if (!e_en[3] && m_stall != 16'hFFFF) m_stall = m_stall + 1;
    if (e_brevt && m_flush != 8'hFF) m_flush = m_flush + 1;
    m_state = e_nstate; m_ret = e_nret; m_wait = e_nwait;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    exMemToReg = 1; exRegWrite = 1; exRd = 3; idRa = 3; exBranchTaken = 1;
    #2;
    n_checks++;
    if (ctl !== 6'b111100) begin
      n_errors++; $display("FAIL reset_outputs: got %b expected %b", ctl, 6'b111100);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({state, memTimeout, stallCycles, flushCount} !== 27'd0) begin
      n_errors++; $display("FAIL reset_state: got st=%b to=%b sc=%0d fc=%0d expected zeros",
                           state, memTimeout, stallCycles, flushCount);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    exMemToReg = 1; exRegWrite = 1; exRd = 5; idRa = 5;
    #1;
    n_checks++;
    if (ctl !== 6'b001101) begin
      n_errors++; $display("FAIL loaduse_run: got %b expected %b", ctl, 6'b001101);
    end
    tick();
    #1;
    n_checks++;
    if (state !== S_BUB || ctl !== 6'b111100) begin
      n_errors++; $display("FAIL loaduse_bubble: got st=%b ctl=%b expected st=01 ctl=111100",
                           state, ctl);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (state !== S_RUN || stallCycles !== 16'd1) begin
      n_errors++; $display("FAIL loaduse_after: got st=%b sc=%0d expected st=00 sc=1",
                           state, stallCycles);
    end
  endtask

  task automatic test_rb_gating();
    do_reset();
    exMemToReg = 1; exRegWrite = 1; exRd = 7; idRb = 7; idRc = 7; idRa = 1;
    #1;
    n_checks++;
    if (pcEn !== 1'b1) begin
      n_errors++; $display("FAIL rb_gated: got pcEn=%b expected 1", pcEn);
    end
    idUsesRb = 1;
    #1;
    n_checks++;
    if (pcEn !== 1'b0) begin
      n_errors++; $display("FAIL rb_used: got pcEn=%b expected 0", pcEn);
    end
    idUsesRb = 0; idIsStore = 1;
    #1;
    n_checks++;
    if (pcEn !== 1'b0) begin
      n_errors++; $display("FAIL rc_store: got pcEn=%b expected 0", pcEn);
    end
    exRegWrite = 0;
    #1;
    n_checks++;
    if (pcEn !== 1'b1) begin
      n_errors++; $display("FAIL no_regwrite: got pcEn=%b expected 1", pcEn);
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    exBranchTaken = 1;
    #1;
    n_checks++;
    if (ctl !== 6'b111111) begin
      n_errors++; $display("FAIL branch_run: got %b expected %b", ctl, 6'b111111);
    end
    tick();
    exBranchTaken = 0;
    #1;
    n_checks++;
    if (state !== S_FL || ctl !== 6'b111110) begin
      n_errors++; $display("FAIL branch_flush: got st=%b ctl=%b expected st=11 ctl=111110",
                           state, ctl);
    end
    tick();
    n_checks++;
    if (state !== S_RUN || flushCount !== 8'd1) begin
      n_errors++; $display("FAIL branch_after: got st=%b fc=%0d expected st=00 fc=1",
                           state, flushCount);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    memReq = 1; memReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ctl !== 6'b000000) begin
        n_errors++; $display("FAIL memwait_hold%0d: got %b expected 000000", i, ctl);
      end
      tick();
    end
    memReady = 1;
    #1;
    n_checks++;
    if (ctl !== 6'b111100) begin
      n_errors++; $display("FAIL memwait_release: got %b expected 111100", ctl);
    end
    tick();
    clear_inputs();
    n_checks++;
    if (state !== S_RUN || stallCycles !== 16'd3 || memTimeout !== 1'b0) begin
      n_errors++; $display("FAIL memwait_after: got st=%b sc=%0d to=%b expected 00 3 0",
                           state, stallCycles, memTimeout);
    end
  endtask

  task automatic test_timeout();
    int  cnt;
    bit  released;
    do_reset();
    memReq = 1; memReady = 0;
    tick();
    cnt = 0; released = 0;
    for (int i = 0; i < 25 && !released; i++) begin
      #1;
      if (state == S_MW) cnt++;
      if (pcEn) released = 1;
      tick();
    end
    memReq = 0;
    n_checks++;
    if (!released || cnt != MemTimeout) begin
      n_errors++; $display("FAIL timeout_len: got rel=%0d waitcycles=%0d expected 1 %0d",
                           released, cnt, MemTimeout);
    end
    n_checks++;
    if (memTimeout !== 1'b1 || stallCycles !== 16'd15) begin
      n_errors++; $display("FAIL timeout_flag: got to=%b sc=%0d expected 1 15",
                           memTimeout, stallCycles);
    end
    repeat (3) tick();
    n_checks++;
    if (memTimeout !== 1'b1 || state !== S_RUN) begin
      n_errors++; $display("FAIL timeout_sticky: got to=%b st=%b expected 1 00", memTimeout, state);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    exMemToReg = 1; exRegWrite = 1; exRd = 5; idRa = 5;
    exBranchTaken = 1; memReq = 1; memReady = 0;
    #1;
    n_checks++;
    if (ctl !== 6'b000000) begin
      n_errors++; $display("FAIL simul_run: got %b expected 000000", ctl);
    end
    tick();
    n_checks++;
    if (state !== S_MW) begin
      n_errors++; $display("FAIL simul_state: got %b expected 10", state);
    end
    tick(); tick();
    memReady = 1;
    #1;
    n_checks++;
    if (ctl !== 6'b111100) begin
      n_errors++; $display("FAIL simul_release: got %b expected 111100", ctl);
    end
    tick();
    memReq = 0; memReady = 0;
    #1;
    n_checks++;
    if (state !== S_RUN || ctl !== 6'b111111) begin
      n_errors++; $display("FAIL simul_branch: got st=%b ctl=%b expected 00 111111", state, ctl);
    end
    tick();
    n_checks++;
    if (state !== S_FL || flushCount !== 8'd1 || stallCycles !== 16'd3) begin
      n_errors++; $display("FAIL simul_after: got st=%b fc=%0d sc=%0d expected 11 1 3",
                           state, flushCount, stallCycles);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush_to_memwait();
    do_reset();
    exBranchTaken = 1;
    tick();
    exBranchTaken = 0; memReq = 1; memReady = 0;
    #1;
    n_checks++;
    if (ctl !== 6'b000000) begin
      n_errors++; $display("FAIL flushmw_stall: got %b expected 000000", ctl);
    end
    tick();
    memReady = 1;
    tick();
    memReq = 0; memReady = 0;
    #1;
    n_checks++;
    if (state !== S_FL || ctl !== 6'b111110) begin
      n_errors++; $display("FAIL flushmw_return: got st=%b ctl=%b expected 11 111110", state, ctl);
    end
    tick();
  endtask

  task automatic test_reset_abandon();
    do_reset();
    memReq = 1; memReady = 0;
    tick(); tick();
    #2 rst = 0;
    #1;
    n_checks++;
    if (state !== S_RUN || stallCycles !== 16'd0 || ctl !== 6'b111100) begin
      n_errors++; $display("FAIL rst_midwait: got st=%b sc=%0d ctl=%b expected 00 0 111100",
                           state, stallCycles, ctl);
    end
    clear_inputs();
    @(posedge clk); #1;
    rst = 1; model_reset();
    exBranchTaken = 1;
    tick();
    exBranchTaken = 0;
    #2 rst = 0;
    #1;
    n_checks++;
    if (state !== S_RUN || ctl !== 6'b111100 || flushCount !== 8'd0) begin
      n_errors++; $display("FAIL rst_midflush: got st=%b ctl=%b fc=%0d expected 00 111100 0",
                           state, ctl, flushCount);
    end
    @(posedge clk); #1;
    rst = 1; model_reset();
    #1;
    n_checks++;
    if (ctl !== 6'b111100) begin
      n_errors++; $display("FAIL rst_nopending: got %b expected 111100", ctl);
    end
  endtask

  task automatic test_flush_saturate();
    do_reset();
    exBranchTaken = 1;
    repeat (260) tick();
    exBranchTaken = 0;
    n_checks++;
    if (flushCount !== 8'd255 || flushCount !== m_flush) begin
      n_errors++; $display("FAIL flush_saturate: got %0d expected 255", flushCount);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      idRa = 4'($urandom_range(0, 3)); idRb = 4'($urandom_range(0, 3));
      idRc = 4'($urandom_range(0, 3)); exRd = 4'($urandom_range(0, 3));
      idUsesRb = 1'($urandom_range(0, 1)); idIsStore = 1'($urandom_range(0, 1));
      exMemToReg = ($urandom_range(0, 3) != 0); exRegWrite = ($urandom_range(0, 3) != 0);
      exBranchTaken = ($urandom_range(0, 7) == 0);
      memReq = ($urandom_range(0, 5) == 0); memReady = ($urandom_range(0, 4) == 0);
      #1;
      model_eval();
      n_checks++;
      if (ctl !== {e_en, e_iff, e_ief} || state !== m_state) begin
        n_errors++; $display("FAIL rand_ctl[%0d]: got st=%b ctl=%b expected st=%b ctl=%b",
                             i, state, ctl, m_state, {e_en, e_iff, e_ief});
      end
      tick();
      n_checks++;
      if (stallCycles !== m_stall || flushCount !== m_flush || memTimeout !== m_timeout) begin
        n_errors++; $display("FAIL rand_cnt[%0d]: got sc=%0d fc=%0d to=%b expected %0d %0d %b",
                             i, stallCycles, flushCount, memTimeout, m_stall, m_flush, m_timeout);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1;
    test_reset();
    test_load_use();
    test_rb_gating();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_simultaneous();
    test_flush_to_memwait();
    test_reset_abandon();
    test_flush_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter Index_size, default 4: width of the register index fields.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum number of MEM_WAIT cycles before a forced release.
REQ-003 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 idRa, idRb, idRc  input  Index_size each  source indices of the instruction in decode.
REQ-007 idUsesRb  input  1  decode instruction reads Rb (register form, immSrc=0).
REQ-008 idIsStore  input  1  decode instruction is a store and reads Rc.
REQ-009 exRd  input  Index_size  destination index held in ID/EX.
REQ-010 exMemToReg, exRegWrite  input  1 each  ID/EX instruction is a load that writes a register.
REQ-011 exBranchTaken  input  1  branch resolved taken in EX.
REQ-012 memReq, memReady  input  1 each  data-memory request and completion handshake from the MEM stage.
REQ-013 pcEn, ifIdEn, idExEn, exMemEn  output  1 each  pipeline register enables.
REQ-014 ifIdFlush, idExFlush  output  1 each  synchronous bubble insert into IF/ID and ID/EX.
REQ-015 state  output  2  FSM encoding: RUN=00, BUBBLE=01, MEM_WAIT=10, FLUSH=11.
REQ-016 memTimeout  output  1  sticky flag for a forced MEM_WAIT release.
REQ-017 stallCycles  output  CNT_W  saturating count of cycles with pcEn=0.
REQ-018 flushCount  output  8  saturating count of taken-branch flush events.

Function
REQ-019 State and counters SHALL be registered; enable and flush outputs SHALL be combinational in the current state and inputs.
REQ-020 loadUse SHALL equal exMemToReg & exRegWrite & ((exRd==idRa) | (idUsesRb & exRd==idRb) | (idIsStore & exRd==idRc)).
REQ-021 memStall SHALL equal memReq & ~memReady.
REQ-022 Priority in RUN, BUBBLE and FLUSH SHALL be: memStall, then exBranchTaken, then loadUse.
REQ-023 memStall in RUN, BUBBLE or FLUSH SHALL drive all four enables to 0 and both flushes to 0, and go to MEM_WAIT.
REQ-024 Entering MEM_WAIT SHALL latch retFlush=1 if the source state is FLUSH, else 0.
REQ-025 RUN with exBranchTaken SHALL drive pcEn=1, all enables 1, ifIdFlush=1, idExFlush=1, and go to FLUSH.
REQ-026 RUN with loadUse SHALL drive pcEn=0, ifIdEn=0, idExEn=1, exMemEn=1, idExFlush=1, and go to BUBBLE.
REQ-027 RUN with no event SHALL drive all enables 1, no flush, and stay in RUN.
REQ-028 BUBBLE SHALL drive all enables 1, ignore loadUse, and go to RUN; exBranchTaken SHALL be handled as in REQ-025.
REQ-029 FLUSH SHALL drive all enables 1 and ifIdFlush=1, ignore loadUse, and go to RUN; exBranchTaken SHALL be handled as in REQ-025.
REQ-030 MEM_WAIT SHALL hold all enables 0, ignore exBranchTaken and loadUse, and increment waitCnt each cycle.
REQ-031 MEM_WAIT with memReady=1 SHALL drive all enables 1 that cycle, clear waitCnt, and go to FLUSH if retFlush=1, else RUN.
REQ-032 When waitCnt==MEM_TIMEOUT-1 in MEM_WAIT, the block SHALL set memTimeout and release exactly as in REQ-031.
REQ-033 memReady and timeout in the same cycle SHALL release once, and memTimeout SHALL still be set.
REQ-034 memTimeout SHALL stay set until reset.
REQ-035 stallCycles SHALL increment every cycle pcEn=0 and saturate at all-ones.
REQ-036 flushCount SHALL increment once per REQ-025 event and saturate at 255.

Reset
REQ-037 rst=0 SHALL immediately force state=RUN, retFlush=0, waitCnt=0, memTimeout=0, stallCycles=0, flushCount=0.
REQ-038 During reset, outputs SHALL be the RUN no-event values: enables 1, flushes 0.
REQ-039 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL abandon the operation with no pending flush.

Verification
REQ-040 Load-use: exMemToReg=1, exRegWrite=1, exRd=5, idRa=5 in RUN -> one cycle with pcEn=0, ifIdEn=0, idExFlush=1; then BUBBLE, then RUN; stallCycles=1.
REQ-041 Rb gating: exRd=7, idRb=7, idUsesRb=0, idIsStore=0 -> no stall; with idUsesRb=1 -> stall.
REQ-042 Branch: exBranchTaken=1 in RUN -> ifIdFlush=idExFlush=1, state goes to FLUSH; next cycle ifIdFlush=1 only; flushCount=1.
REQ-043 Memory wait: memReq=1, memReady=0 for 3 cycles then memReady=1 -> enables 0 for 3 cycles, 1 on the 4th; stallCycles=3; memTimeout=0.
REQ-044 Timeout: memReq=1, memReady=0 held -> release after 15 MEM_WAIT cycles; memTimeout=1 and stays set after memReq drops.
REQ-045 Simultaneous events: memStall, exBranchTaken and loadUse in one RUN cycle -> MEM_WAIT; on release, the branch is flushed per REQ-025; async reset mid-wait -> RUN, counters 0.
